mandel_iter: RTL and testbench

- Escape-time iteration core for the Mandelbrot renderer. Consumes one Q4.28 point c = (c_re, c_im) from the pixel coordinate stage.
- Iterates z <- z^2 + c using three internal fixed_mul instances: zr*zr, zi*zi and zr*zi.
- Returns the iteration count and an escape flag to the colour-mapping stage.
- Sits directly downstream of the coordinate generator and is the sole consumer of the fixed_mul results.

---
 rtl/mandel_iter.sv | 220 ++++++++++++++++++++++
 tb/tb_mandel_iter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mandel_iter.sv
// Mandelbrot escape-time core: iterates z <- z^2 + c in Q4.28 using three pipelined fixed_mul units.
// Optional MANDEL_ITER_CYCLES_EN adds a saturating 32-bit cycle counter output (cycles).

module fixed_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic                    i_valid,
  output logic signed [WIDTH-1:0] o_p,
  output logic                    o_valid
);
  logic signed [WIDTH-1:0]   r_a, r_b, r_p;
  logic                      r_v1, r_v2;
  logic signed [2*WIDTH-1:0] w_prod;

  // Operands widened first so the low 2*WIDTH bits hold the exact signed product.
  assign w_prod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_p  <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      if (i_valid) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      if (r_v1) r_p <= WIDTH'(w_prod >>> FRAC);
    end
  end

  assign o_p     = r_p;
  assign o_valid = r_v2;
endmodule

module mandel_iter #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  input  logic [ITER_W-1:0]       max_iter,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [ITER_W-1:0]       iter_count,
  output logic                    escaped
`ifdef MANDEL_ITER_CYCLES_EN
  ,
  output logic [31:0]             cycles
`endif
);
  localparam int SW = WIDTH + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [WIDTH:0]        TWO  = (WIDTH+1)'(1) << (FRAC + 1);
  localparam logic signed [WIDTH:0] FOUR = (WIDTH+1)'(1) << (FRAC + 2);

  logic [2:0]              r_state;
  logic signed [WIDTH-1:0] r_c_re, r_c_im, r_zr, r_zi;
  logic signed [WIDTH-1:0] r_zr2, r_zi2, r_zrzi;
  logic [ITER_W-1:0]       r_max, r_n, r_iter_count;
  logic                    r_escaped;
  logic [2:0]              r_got;

  logic                    w_mul_go;
  logic signed [WIDTH-1:0] w_p_rr, w_p_ii, w_p_ri;
  logic                    w_v_rr, w_v_ii, w_v_ri;
  logic [2:0]              w_got_all;
  logic signed [WIDTH:0]   w_mag;
  logic signed [SW-1:0]    w_re_sum, w_im_sum;
  logic                    w_out_of_box;

  function automatic logic [WIDTH:0] f_abs(input logic signed [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? ((~ext) + (WIDTH+1)'(1)) : ext;
  endfunction

  // Result fits when the bits from WIDTH-1 upward are all sign copies.
  function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [SW-1:0] x);
    if ((&x[SW-1:WIDTH-1]) || !(|x[SW-1:WIDTH-1]))
      return x[WIDTH-1:0];
    else if (x[SW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign w_mul_go = (r_state == S_MUL);

  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (
    .clk(clk), .rst_n(rst_n), .i_a(r_zr), .i_b(r_zr), .i_valid(w_mul_go),
    .o_p(w_p_rr), .o_valid(w_v_rr));
  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (
    .clk(clk), .rst_n(rst_n), .i_a(r_zi), .i_b(r_zi), .i_valid(w_mul_go),
    .o_p(w_p_ii), .o_valid(w_v_ii));
  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (
    .clk(clk), .rst_n(rst_n), .i_a(r_zr), .i_b(r_zi), .i_valid(w_mul_go),
    .o_p(w_p_ri), .o_valid(w_v_ri));

  assign w_got_all    = r_got | {w_v_ri, w_v_ii, w_v_rr};
  assign w_out_of_box = (f_abs(r_zr) > TWO) || (f_abs(r_zi) > TWO);
  assign w_mag        = (WIDTH+1)'(r_zr2) + (WIDTH+1)'(r_zi2);
  assign w_re_sum     = SW'(r_zr2) - SW'(r_zi2) + SW'(r_c_re);
  assign w_im_sum     = (SW'(r_zrzi) <<< 1) + SW'(r_c_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_c_re       <= '0;
      r_c_im       <= '0;
      r_max        <= '0;
      r_zr         <= '0;
      r_zi         <= '0;
      r_zr2        <= '0;
      r_zi2        <= '0;
      r_zrzi       <= '0;
      r_n          <= '0;
      r_got        <= '0;
      r_iter_count <= '0;
      r_escaped    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_c_re  <= c_re;
            r_c_im  <= c_im;
            r_max   <= max_iter;
            r_zr    <= '0;
            r_zi    <= '0;
            r_n     <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_n == r_max) begin
            r_iter_count <= r_n;
            r_escaped    <= 1'b0;
            r_state      <= S_DONE;
          end else if (w_out_of_box) begin
            r_iter_count <= r_n;
            r_escaped    <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_got   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Each product is captured on its own valid, so unequal latencies are fine.
          if (w_v_rr) r_zr2  <= w_p_rr;
          if (w_v_ii) r_zi2  <= w_p_ii;
          if (w_v_ri) r_zrzi <= w_p_ri;
          r_got <= w_got_all;
          if (&w_got_all) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (w_mag > FOUR) begin
            r_iter_count <= r_n;
            r_escaped    <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_zr    <= f_sat(w_re_sum);
            r_zi    <= f_sat(w_im_sum);
            r_n     <= r_n + ITER_W'(1);
            r_state <= S_CHECK;
          end
        end
        S_DONE: begin
          if (done_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign iter_count  = r_iter_count;
  assign escaped     = r_escaped;

`ifdef MANDEL_ITER_CYCLES_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (start_valid) r_cycles <= '0;
    end else if (r_state != S_DONE) begin
      if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles = r_cycles;
`endif
endmodule

// File: tb/tb_mandel_iter.sv
// Directed self-checking bench for mandel_iter; define MANDEL_ITER_CYCLES_EN to also check cycles.

module tb_mandel_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_re = '0, c_im = '0;
  logic [15:0] max_iter = '0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [15:0] iter_count;
  logic        escaped;
`ifdef MANDEL_ITER_CYCLES_EN
  logic [31:0] cycles;
  logic [31:0] last_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mandel_iter dut (
    .clk(clk), .rst_n(rst_n), .c_re(c_re), .c_im(c_im), .max_iter(max_iter),
    .start_valid(start_valid), .start_ready(start_ready),
    .done_valid(done_valid), .done_ready(done_ready),
    .iter_count(iter_count), .escaped(escaped)
`ifdef MANDEL_ITER_CYCLES_EN
    , .cycles(cycles)
`endif
  );

  // Issue one point and wait (bounded) for its result.
  task automatic run_point(input logic [31:0] cre, input logic [31:0] cim,
                           input logic [15:0] mi, input bit release_done,
                           output logic [15:0] cnt, output logic esc, output bit to);
    int k;
    to = 0;
    for (k = 0; k < 50 && !start_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!start_ready) begin
      to = 1;
      return;
    end
    c_re = cre; c_im = cim; max_iter = mi; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (k = 0; k < 5000 && !done_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!done_valid) begin
      to = 1;
      return;
    end
    cnt = iter_count;
    esc = escaped;
`ifdef MANDEL_ITER_CYCLES_EN
    last_cycles = cycles;
`endif
    if (release_done) begin
      done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_vec++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    n_vec++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done_valid got %b want 0", done_valid); end
    n_vec++; if (iter_count !== 16'd0) begin n_bad++; $display("FAIL reset_iter_count got %0d want 0", iter_count); end
    n_vec++; if (escaped !== 1'b0) begin n_bad++; $display("FAIL reset_escaped got %b want 0", escaped); end
`ifdef MANDEL_ITER_CYCLES_EN
    n_vec++; if (cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got %0d want 0", cycles); end
`endif
    $display("reset: start_ready=%b done_valid=%b iter_count=%0d escaped=%b", start_ready, done_valid, iter_count, escaped);
  endtask

  task automatic test_point(input string name, input logic [31:0] cre, input logic [31:0] cim,
                            input logic [15:0] mi, input logic [15:0] exp_cnt, input logic exp_esc);
    logic [15:0] cnt; logic esc; bit to;
    cnt = 'x; esc = 'x;
    run_point(cre, cim, mi, 1'b1, cnt, esc, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL %s_timeout got no handshake want done", name); end
    n_vec++; if (cnt !== exp_cnt) begin n_bad++; $display("FAIL %s_iter_count got %0d want %0d", name, cnt, exp_cnt); end
    n_vec++; if (esc !== exp_esc) begin n_bad++; $display("FAIL %s_escaped got %b want %b", name, esc, exp_esc); end
    $display("%s: c=(%h,%h) max=%0d -> iter_count=%0d escaped=%b", name, cre, cim, mi, cnt, esc);
  endtask

  // c=1: 3 iterations of 5 cycles (CHECK, MUL, 2x WAIT, UPDATE) plus the final CHECK.
  task automatic test_escape_one();
    test_point("escape_one", 32'h1000_0000, 32'h0, 16'd50, 16'd3, 1'b1);
`ifdef MANDEL_ITER_CYCLES_EN
    n_vec++; if (last_cycles !== 32'd16) begin n_bad++; $display("FAIL escape_one_cycles got %0d want 16", last_cycles); end
`endif
  endtask

  task automatic test_max_zero();
    test_point("max_zero", 32'h0, 32'h1000_0000, 16'd0, 16'd0, 1'b0);
`ifdef MANDEL_ITER_CYCLES_EN
    n_vec++; if (last_cycles !== 32'd1) begin n_bad++; $display("FAIL max_zero_cycles got %0d want 1", last_cycles); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] cnt; logic esc; bit to;
    cnt = 'x; esc = 'x;
    run_point(32'h1000_0000, 32'h0, 16'd50, 1'b0, cnt, esc, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL hold_timeout got no done want done"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL hold_done_valid cyc%0d got %b want 1", i, done_valid); end
      n_vec++; if (start_ready !== 1'b0) begin n_bad++; $display("FAIL hold_start_ready cyc%0d got %b want 0", i, start_ready); end
      n_vec++; if (iter_count !== 16'd3) begin n_bad++; $display("FAIL hold_iter_count cyc%0d got %0d want 3", i, iter_count); end
      n_vec++; if (escaped !== 1'b1) begin n_bad++; $display("FAIL hold_escaped cyc%0d got %b want 1", i, escaped); end
      $display("hold cyc%0d: done_valid=%b start_ready=%b iter_count=%0d escaped=%b", i, done_valid, start_ready, iter_count, escaped);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    n_vec++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL release_done_valid got %b want 0", done_valid); end
    n_vec++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL release_start_ready got %b want 1", start_ready); end
    $display("release: done_valid=%b start_ready=%b", done_valid, start_ready);
  endtask

  task automatic test_reset_mid_wait();
    c_re = 32'h0; c_im = 32'h0; max_iter = 16'd100; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_start_ready got %b want 1", start_ready); end
    n_vec++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_done_valid got %b want 0", done_valid); end
    n_vec++; if (iter_count !== 16'd0) begin n_bad++; $display("FAIL midrst_iter_count got %0d want 0", iter_count); end
    n_vec++; if (escaped !== 1'b0) begin n_bad++; $display("FAIL midrst_escaped got %b want 0", escaped); end
    $display("mid-wait reset: start_ready=%b done_valid=%b iter_count=%0d escaped=%b", start_ready, done_valid, iter_count, escaped);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_point("after_reset", 32'h2000_0000, 32'h2000_0000, 16'd10, 16'd1, 1'b1);
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_point("origin", 32'h0, 32'h0, 16'd100, 16'd100, 1'b0);
    test_escape_one();
    test_point("minus_two", 32'hE000_0000, 32'h0, 16'd20, 16'd20, 1'b0);
    test_point("two_two", 32'h2000_0000, 32'h2000_0000, 16'd10, 16'd1, 1'b1);
    test_max_zero();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
